reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 24 ++
 rtl/reset_sequencer_if.sv | 27 ++
 rtl/rst_sync_2ff.sv | 21 ++
 rtl/reset_sequencer.sv | 107 ++++++++++
 tb/tb_reset_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// counter width, default parameter values and a counter-width helper.
package reset_seq_pkg;

  localparam int unsigned CNT_W           = 32;
  localparam int unsigned DEF_HOLD_CYCLES = 25;
  localparam int unsigned DEF_N_CH        = 2;
  localparam int unsigned DEF_STAGGER     = 4;
  localparam int unsigned DEF_TIMEOUT     = 500;

  typedef enum logic [2:0] {
    ASSERT  = 3'd0,
    RELEASE = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TRIP    = 3'd4
  } seq_state_t;

  // Bits needed to hold values 0..maxval, never less than one.
  function automatic int unsigned cnt_w(input int unsigned maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer (master) and the logic it
// controls (slave): requests in, per-channel resets and status out.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_CH = DEF_N_CH
);

  logic             soft_rst_req;
  logic             done_in;
  logic [N_CH-1:0]  rst_out;
  logic             all_released;
  logic [CNT_W-1:0] cycle_cnt;
  logic             finished;
  logic             timeout;

  modport master (
    input  soft_rst_req, done_in,
    output rst_out, all_released, cycle_cnt, finished, timeout
  );

  modport slave (
    output soft_rst_req, done_in,
    input  rst_out, all_released, cycle_cnt, finished, timeout
  );

endinterface

// File: rtl/rst_sync_2ff.sv
// Reset synchroniser: asserts asynchronously with rst, releases two clocks
// after rst falls so the FSM never sees a deassertion near a clock edge.
module rst_sync_2ff (
  input  logic clk,
  input  logic rst,
  output logic srst
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      srst <= 1'b1;
    end else begin
      meta <= 1'b0;
      srst <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staggered multi-channel reset sequencer with run-cycle counter and optional
// watchdog (enabled by defining RESET_SEQUENCER_WDT_EN).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned STAGGER     = DEF_STAGGER,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  reset_sequencer_if.master   seq
);

`ifdef RESET_SEQUENCER_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  localparam int unsigned HOLD_W   = cnt_w(HOLD_CYCLES - 1);
  localparam int unsigned REL_LAST = (N_CH - 1) * STAGGER;
  localparam int unsigned REL_W    = cnt_w(REL_LAST);

  logic             srst;
  seq_state_t       state;
  logic [HOLD_W-1:0] hold_q;
  logic [REL_W-1:0]  rel_q;
  logic [N_CH-1:0]   rst_out_q;
  logic              all_rel_q;
  logic [CNT_W-1:0]  cycle_q;
  logic              fin_q;
  logic              tmo_q;

  rst_sync_2ff u_sync (
    .clk  (clk),
    .rst  (rst),
    .srst (srst)
  );

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state     <= ASSERT;
      hold_q    <= '0;
      rel_q     <= '0;
      rst_out_q <= '1;
      all_rel_q <= 1'b0;
      cycle_q   <= '0;
      fin_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else if (seq.soft_rst_req) begin
      state     <= ASSERT;
      hold_q    <= '0;
      rel_q     <= '0;
      rst_out_q <= '1;
      all_rel_q <= 1'b0;
      cycle_q   <= '0;
      fin_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      case (state)
        ASSERT: begin
          if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            state  <= RELEASE;
            hold_q <= '0;
            rel_q  <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        RELEASE: begin
          for (int unsigned k = 0; k < N_CH; k++) begin
            if (rel_q == REL_W'(k * STAGGER)) rst_out_q[k] <= 1'b0;
          end
          // Last channel drops on the same edge the FSM enters RUN.
          if (rel_q == REL_W'(REL_LAST)) begin
            state     <= RUN;
            all_rel_q <= 1'b1;
          end else begin
            rel_q <= rel_q + 1'b1;
          end
        end
        RUN: begin
          if (seq.done_in) begin
            state <= DONE;
            fin_q <= 1'b1;
          end else begin
            if (cycle_q != '1) cycle_q <= cycle_q + 1'b1;
            if (WDT_EN && (TIMEOUT != 0) && (cycle_q == CNT_W'(TIMEOUT - 1))) begin
              state <= TRIP;
              tmo_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign seq.rst_out      = rst_out_q;
  assign seq.all_released = all_rel_q;
  assign seq.cycle_cnt    = cycle_q;
  assign seq.finished     = fin_q;
  assign seq.timeout      = tmo_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer: default 2-channel build
// plus an 8-channel, STAGGER=1 instance.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst8;
  int   n_assert;
  int   n_fail;

  always #5 clk = ~clk;

  reset_sequencer_if #(.N_CH(2)) bus0 ();
  reset_sequencer_if #(.N_CH(8)) bus8 ();

  reset_sequencer #(
    .HOLD_CYCLES (25),
    .N_CH        (2),
    .STAGGER     (4),
    .TIMEOUT     (500)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .seq (bus0)
  );

  reset_sequencer #(
    .HOLD_CYCLES (25),
    .N_CH        (8),
    .STAGGER     (1),
    .TIMEOUT     (500)
  ) dut8 (
    .clk (clk),
    .rst (rst8),
    .seq (bus8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic soft_pulse();
    bus0.soft_rst_req = 1'b1;
    @(negedge clk);
    bus0.soft_rst_req = 1'b0;
  endtask

  initial begin
    logic [7:0] m8;
    n_assert = 0;
    n_fail   = 0;
    rst  = 1'b0;
    rst8 = 1'b0;
    bus0.soft_rst_req = 1'b0;
    bus0.done_in      = 1'b0;
    bus8.soft_rst_req = 1'b0;
    bus8.done_in      = 1'b0;
    #1;
    rst  = 1'b1;
    rst8 = 1'b1;

    // Reset values while rst held high
    repeat (25) @(negedge clk);
    chk("rst_rst_out",   32'(bus0.rst_out), 32'h3);
    chk("rst_all_rel",   32'(bus0.all_released), 0);
    chk("rst_cycle_cnt", bus0.cycle_cnt, 0);
    chk("rst_finished",  32'(bus0.finished), 0);
    chk("rst_timeout",   32'(bus0.timeout), 0);
    chk("rst_state",     32'(dut0.state), 32'(ASSERT));
    chk("rst8_rst_out",  32'(bus8.rst_out), 32'hFF);

    // 2 sync clocks + 25 hold clocks, then staggered release
    rst = 1'b0;
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk);
      chk("hold_rst_out", 32'(bus0.rst_out), 32'h3);
    end
    @(negedge clk);
    chk("ch0_release", 32'(bus0.rst_out), 32'h2);
    chk("ch0_all_rel", 32'(bus0.all_released), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stagger_gap", 32'(bus0.rst_out), 32'h2);
    end
    @(negedge clk);
    chk("ch1_release", 32'(bus0.rst_out), 32'h0);
    chk("ch1_all_rel", 32'(bus0.all_released), 1);
    chk("run_state",   32'(dut0.state), 32'(RUN));
    chk("run_cnt0",    bus0.cycle_cnt, 0);

    // done_in on RUN clock 100
    repeat (100) @(negedge clk);
    chk("run_cnt100", bus0.cycle_cnt, 100);
    bus0.done_in = 1'b1;
    @(negedge clk);
    bus0.done_in = 1'b0;
    chk("done_finished", 32'(bus0.finished), 1);
    chk("done_state",    32'(dut0.state), 32'(DONE));
    chk("done_cnt",      bus0.cycle_cnt, 100);
    chk("done_timeout",  32'(bus0.timeout), 0);
    repeat (5) @(negedge clk);
    bus0.done_in = 1'b1;
    @(negedge clk);
    bus0.done_in = 1'b0;
    chk("done_frozen_cnt", bus0.cycle_cnt, 100);
    chk("done_terminal",   32'(dut0.state), 32'(DONE));

    // Soft reset from DONE; done_in during ASSERT is ignored
    soft_pulse();
    chk("soft_rst_out",  32'(bus0.rst_out), 32'h3);
    chk("soft_all_rel",  32'(bus0.all_released), 0);
    chk("soft_finished", 32'(bus0.finished), 0);
    chk("soft_cnt",      bus0.cycle_cnt, 0);
    chk("soft_state",    32'(dut0.state), 32'(ASSERT));
    bus0.done_in = 1'b1;
    repeat (10) @(negedge clk);
    bus0.done_in = 1'b0;
    chk("assert_done_ignored", 32'(bus0.finished), 0);
    chk("assert_state",        32'(dut0.state), 32'(ASSERT));
    repeat (15) @(negedge clk);
    chk("soft_hold_end", 32'(bus0.rst_out), 32'h3);
    @(negedge clk);
    chk("soft_ch0_rel", 32'(bus0.rst_out), 32'h2);
    chk("soft_rel_state", 32'(dut0.state), 32'(RELEASE));

    // Soft reset mid-RELEASE re-asserts everything and restarts the hold
    soft_pulse();
    chk("rel_abort_rst_out", 32'(bus0.rst_out), 32'h3);
    chk("rel_abort_state",   32'(dut0.state), 32'(ASSERT));
    repeat (25) @(negedge clk);
    chk("rel_abort_hold", 32'(bus0.rst_out), 32'h3);
    @(negedge clk);
    chk("rel_abort_ch0", 32'(bus0.rst_out), 32'h2);
    repeat (3) @(negedge clk);
    chk("rel_abort_gap", 32'(bus0.rst_out), 32'h2);
    @(negedge clk);
    chk("rel_abort_ch1",    32'(bus0.rst_out), 32'h0);
    chk("rel_abort_allrel", 32'(bus0.all_released), 1);

    // done_in on the clock cycle_cnt = TIMEOUT-1: done wins
    repeat (499) @(negedge clk);
    chk("edge_cnt499", bus0.cycle_cnt, 499);
    bus0.done_in = 1'b1;
    @(negedge clk);
    bus0.done_in = 1'b0;
    chk("edge_finished", 32'(bus0.finished), 1);
    chk("edge_timeout",  32'(bus0.timeout), 0);
    chk("edge_cnt",      bus0.cycle_cnt, 499);
    chk("edge_state",    32'(dut0.state), 32'(DONE));

    // Watchdog with done_in held low
    soft_pulse();
    repeat (30) @(negedge clk);
    chk("wdt_run_entry", 32'(bus0.all_released), 1);
    chk("wdt_cnt0",      bus0.cycle_cnt, 0);
    repeat (500) @(negedge clk);
`ifdef RESET_SEQUENCER_WDT_EN
    chk("wdt_timeout", 32'(bus0.timeout), 1);
    chk("wdt_cnt",     bus0.cycle_cnt, 500);
    chk("wdt_state",   32'(dut0.state), 32'(TRIP));
    repeat (600) @(negedge clk);
    chk("wdt_timeout_sticky", 32'(bus0.timeout), 1);
    chk("wdt_cnt_frozen",     bus0.cycle_cnt, 500);
`else
    chk("nowdt_timeout", 32'(bus0.timeout), 0);
    chk("nowdt_cnt",     bus0.cycle_cnt, 500);
    chk("nowdt_state",   32'(dut0.state), 32'(RUN));
    repeat (600) @(negedge clk);
    chk("nowdt_timeout_late", 32'(bus0.timeout), 0);
    chk("nowdt_cnt_late",     bus0.cycle_cnt, 1100);
`endif

    // rst pulse between edges mid-RUN
    soft_pulse();
    repeat (30) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("pulse_pre_cnt", bus0.cycle_cnt, 20);
    #2 rst = 1'b1;
    #1;
    chk("pulse_rst_out", 32'(bus0.rst_out), 32'h3);
    chk("pulse_cnt",     bus0.cycle_cnt, 0);
    chk("pulse_all_rel", 32'(bus0.all_released), 0);
    chk("pulse_state",   32'(dut0.state), 32'(ASSERT));
    #1 rst = 1'b0;
    @(negedge clk);
    repeat (26) @(negedge clk);
    chk("pulse_hold", 32'(bus0.rst_out), 32'h3);
    @(negedge clk);
    chk("pulse_ch0", 32'(bus0.rst_out), 32'h2);

    // 8 channels, STAGGER=1: consecutive ascending releases
    rst8 = 1'b0;
    repeat (27) @(negedge clk);
    chk("ch8_hold", 32'(bus8.rst_out), 32'hFF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      m8 = 8'hFF << (k + 1);
      chk("ch8_release", 32'(bus8.rst_out), 32'(m8));
    end
    chk("ch8_all_rel", 32'(bus8.all_released), 1);
    chk("ch8_state",   32'(dut8.state), 32'(RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
